// File: rtl/otter_pkg.sv
// rtl/otter_pkg.sv - opcode constants, FSM state encoding and strobe bundle for the control unit
package otter_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_MRET    = 3'b000;
    localparam logic [2:0] F3_CSRRW   = 3'b001;

    localparam int INSTRET_W = 32;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } state_t;

    typedef struct packed {
        logic pc_we;
        logic rf_we;
        logic mem_we2;
        logic mem_rden1;
        logic mem_rden2;
        logic csr_we;
        logic int_taken;
        logic mret_exec;
        logic reset;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    // Instructions that write the register file in the same cycle they execute.
    function automatic logic is_rf_alu(input logic [6:0] op);
        return (op == OPC_OP)  || (op == OPC_OP_IMM) || (op == OPC_LUI) ||
               (op == OPC_AUIPC) || (op == OPC_JAL) || (op == OPC_JALR);
    endfunction

endpackage

// File: rtl/instret_cnt.sv
// rtl/instret_cnt.sv - retired-instruction counter with synchronous clear and count enable
module instret_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Clear dominates so a reset on a retiring edge still lands on zero.
    assign cnt_d = clr_i ? '0 : (en_i ? cnt_q + WIDTH'(1) : cnt_q);

    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/cu_fsm.sv
// rtl/cu_fsm.sv - multicycle control unit: fetch/exec/writeback/interrupt sequencing and strobes
module cu_fsm
    import otter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        intr,
    input  logic        mie,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    output logic        PC_WE,
    output logic        RF_WE,
    output logic        memWE2,
    output logic        memRDEN1,
    output logic        memRDEN2,
    output logic        csr_WE,
    output logic        int_taken,
    output logic        mret_exec,
    output logic        reset,
    output logic [31:0] instret
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;
    logic   is_load;
    logic   intr_req;
    logic   retire;

    assign is_load  = (opcode == OPC_LOAD);
    assign intr_req = intr & mie;
    assign retire   = ((state_q == ST_EXEC) && !is_load) || (state_q == ST_WB);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Interrupts are only sampled at an instruction boundary (EXEC or WB exit).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  state_d = ST_FETCH;
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                if (is_load) begin
                    state_d = ST_WB;
                end else if (intr_req) begin
                    state_d = ST_INTR;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_WB:    state_d = intr_req ? ST_INTR : ST_FETCH;
            ST_INTR:  state_d = ST_FETCH;
            default:  state_d = ST_INIT;
        endcase
    end

    always_comb begin
        ctrl = CTRL_NONE;
        case (state_q)
            ST_INIT:  ctrl.reset     = 1'b1;
            ST_FETCH: ctrl.mem_rden1 = 1'b1;
            ST_EXEC: begin
                if (opcode == OPC_LOAD) begin
                    ctrl.mem_rden2 = 1'b1;
                end else begin
                    ctrl.pc_we = 1'b1;
                    if (opcode == OPC_STORE) begin
                        ctrl.mem_we2 = 1'b1;
                    end else if (is_rf_alu(opcode)) begin
                        ctrl.rf_we = 1'b1;
                    end else if (opcode == OPC_SYSTEM && func3 == F3_CSRRW) begin
                        ctrl.csr_we = 1'b1;
                        ctrl.rf_we  = 1'b1;
                    end else if (opcode == OPC_SYSTEM && func3 == F3_MRET) begin
                        ctrl.mret_exec = 1'b1;
                    end
                end
            end
            ST_WB: begin
                ctrl.rf_we = 1'b1;
                ctrl.pc_we = 1'b1;
            end
            ST_INTR: begin
                ctrl.int_taken = 1'b1;
                ctrl.pc_we     = 1'b1;
            end
            default:  ctrl = CTRL_NONE;
        endcase
    end

    assign PC_WE     = ctrl.pc_we;
    assign RF_WE     = ctrl.rf_we;
    assign memWE2    = ctrl.mem_we2;
    assign memRDEN1  = ctrl.mem_rden1;
    assign memRDEN2  = ctrl.mem_rden2;
    assign csr_WE    = ctrl.csr_we;
    assign int_taken = ctrl.int_taken;
    assign mret_exec = ctrl.mret_exec;
    assign reset     = ctrl.reset;

    instret_cnt #(
        .WIDTH (INSTRET_W)
    ) u_instret (
        .clk_i   (clk),
        .clr_i   (~rst),
        .en_i    (retire),
        .count_o (instret)
    );

endmodule

// File: tb/tb_cu_fsm.sv
// tb/tb_cu_fsm.sv - instruction-level reference model bench for cu_fsm
module tb_cu_fsm;

    localparam logic [8:0] B_PC   = 9'b1_0000_0000;
    localparam logic [8:0] B_RF   = 9'b0_1000_0000;
    localparam logic [8:0] B_WE2  = 9'b0_0100_0000;
    localparam logic [8:0] B_RD1  = 9'b0_0010_0000;
    localparam logic [8:0] B_RD2  = 9'b0_0001_0000;
    localparam logic [8:0] B_CSR  = 9'b0_0000_1000;
    localparam logic [8:0] B_INT  = 9'b0_0000_0100;
    localparam logic [8:0] B_MRET = 9'b0_0000_0010;
    localparam logic [8:0] B_RST  = 9'b0_0000_0001;

    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] BR     = 7'b1100011;
    localparam logic [6:0] OPR    = 7'b0110011;
    localparam logic [6:0] ADDI   = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] SYS    = 7'b1110011;

    logic        clk = 1'b0;
    logic        rst;
    logic        intr;
    logic        mie;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic        PC_WE, RF_WE, memWE2, memRDEN1, memRDEN2;
    logic        csr_WE, int_taken, mret_exec, reset;
    logic [31:0] instret;

    int          passed = 0;
    int          failed = 0;
    int          total  = 0;
    logic [31:0] m_cnt  = 32'd0;
    logic        preload_req = 1'b0;
    logic        forced      = 1'b0;
    logic [6:0]  op_pool [10] = '{LW, SW, BR, OPR, ADDI, LUI, AUIPC, JAL, JALR, SYS};

    cu_fsm dut (
        .clk       (clk),
        .rst       (rst),
        .intr      (intr),
        .mie       (mie),
        .opcode    (opcode),
        .func3     (func3),
        .PC_WE     (PC_WE),
        .RF_WE     (RF_WE),
        .memWE2    (memWE2),
        .memRDEN1  (memRDEN1),
        .memRDEN2  (memRDEN2),
        .csr_WE    (csr_WE),
        .int_taken (int_taken),
        .mret_exec (mret_exec),
        .reset     (reset),
        .instret   (instret)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] exp_exec(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            LW:                               return B_RD2;
            SW:                               return B_WE2 | B_PC;
            BR:                               return B_PC;
            OPR, ADDI, LUI, AUIPC, JAL, JALR: return B_PC | B_RF;
            SYS: begin
                if (f3 == 3'b001) return B_CSR | B_RF | B_PC;
                if (f3 == 3'b000) return B_MRET | B_PC;
                return B_PC;
            end
            default:                          return B_PC;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // One clock cycle: drive at the falling edge, compare just after it.
    task automatic step(input logic r, input logic [6:0] op, input logic [2:0] f3,
                        input logic ix, input logic mx, input logic [8:0] exp_vec, input string tag);
        @(negedge clk);
        if (forced) begin
            release dut.u_instret.cnt_d;
            forced = 1'b0;
        end
        rst = r; opcode = op; func3 = f3; intr = ix; mie = mx;
        if (preload_req) begin
            force dut.u_instret.cnt_d = 32'hFFFF_FFFF;
            forced      = 1'b1;
            preload_req = 1'b0;
        end
        #1;
        check({tag, "_strobes"}, {23'd0, PC_WE, RF_WE, memWE2, memRDEN1, memRDEN2,
                                  csr_WE, int_taken, mret_exec, reset}, {23'd0, exp_vec});
        check({tag, "_instret"}, instret, m_cnt);
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic ix, input logic mx, input string tag);
        logic pre;
        pre = preload_req;
        step(1'b1, op, f3, 1'($urandom), 1'($urandom), B_RD1, {tag, "_fetch"});
        if (pre) m_cnt = 32'hFFFF_FFFF;
        if (op == LW) begin
            step(1'b1, op, f3, 1'($urandom), 1'($urandom), B_RD2, {tag, "_exec"});
            step(1'b1, op, f3, ix, mx, B_PC | B_RF, {tag, "_wb"});
        end else begin
            step(1'b1, op, f3, ix, mx, exp_exec(op, f3), {tag, "_exec"});
        end
        m_cnt = m_cnt + 32'd1;
        if (ix & mx) begin
            step(1'b1, op, f3, 1'($urandom), 1'($urandom), B_PC | B_INT, {tag, "_intr"});
        end
    endtask

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        logic       ix;
        logic       mx;

        rst = 1'b0; intr = 1'b0; mie = 1'b0; opcode = ADDI; func3 = 3'd0;
        @(negedge clk);
        m_cnt = 32'd0;
        step(1'b0, ADDI, 3'd0, 1'b1, 1'b1, B_RST, "rst_hold");
        step(1'b1, ADDI, 3'd0, 1'b1, 1'b1, B_RST, "rst_release");

        run_instr(ADDI, 3'd0, 1'b0, 1'b0, "addi0");
        run_instr(ADDI, 3'd0, 1'b0, 1'b0, "addi1");
        run_instr(ADDI, 3'd5, 1'b0, 1'b1, "addi2");
        run_instr(LW,   3'd2, 1'b0, 1'b1, "lw0");
        run_instr(SW,   3'd2, 1'b1, 1'b1, "sw_int");
        run_instr(SW,   3'd2, 1'b1, 1'b0, "sw_nomie");
        run_instr(LW,   3'd2, 1'b1, 1'b1, "lw_int");
        run_instr(BR,   3'd1, 1'b0, 1'b0, "br");
        run_instr(SYS,  3'b001, 1'b0, 1'b0, "csrrw");
        run_instr(SYS,  3'b000, 1'b1, 1'b1, "mret");
        run_instr(SYS,  3'b010, 1'b0, 1'b0, "sys_other");
        run_instr(7'b1111111, 3'd0, 1'b0, 1'b0, "nop_op");

        preload_req = 1'b1;
        run_instr(SYS, 3'b001, 1'b0, 1'b0, "wrap");
        check("wrap_zero", {31'd0, m_cnt == 32'd0}, 32'd1);
        run_instr(ADDI, 3'd0, 1'b0, 1'b0, "after_wrap");

        step(1'b1, LW, 3'd2, 1'b0, 1'b0, B_RD1, "rstwb_fetch");
        step(1'b1, LW, 3'd2, 1'b0, 1'b0, B_RD2, "rstwb_exec");
        step(1'b0, LW, 3'd2, 1'b1, 1'b1, B_PC | B_RF, "rstwb_wb");
        m_cnt = 32'd0;
        step(1'b1, LW, 3'd2, 1'b1, 1'b1, B_RST, "rstwb_init");

        for (int i = 0; i < 80; i++) begin
            op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : op_pool[$urandom_range(0, 9)];
            f3 = (op == SYS) ? 3'($urandom_range(0, 3)) : 3'($urandom);
            ix = 1'($urandom);
            mx = 1'($urandom);
            run_instr(op, f3, ix, mx, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
